// File: rtl/writeback_stage_if.sv
// rtl/writeback_stage_if.sv - memory-stage result bundle and decode register-file write port
interface writeback_stage_if #(
    parameter int PC_WIDTH     = 16,
    parameter int REG_WIDTH    = 32,
    parameter int OPCODE_WIDTH = 8
);
    logic                    I_LOCK;
    logic [PC_WIDTH-1:0]     I_PC;
    logic [OPCODE_WIDTH-1:0] I_Opcode;
    logic [REG_WIDTH-1:0]    I_ALUOut;
    logic [REG_WIDTH-1:0]    I_MemOut;
    logic [3:0]              I_DestRegIdx;
    logic                    I_FetchStall;
    logic                    I_DepStall;
    logic                    O_WriteBackEnable;
    logic [3:0]              O_WriteBackRegIdx;
    logic [REG_WIDTH-1:0]    O_WriteBackData;

    modport master (
        output I_LOCK, I_PC, I_Opcode, I_ALUOut, I_MemOut, I_DestRegIdx, I_FetchStall, I_DepStall,
        input  O_WriteBackEnable, O_WriteBackRegIdx, O_WriteBackData
    );

    modport slave (
        input  I_LOCK, I_PC, I_Opcode, I_ALUOut, I_MemOut, I_DestRegIdx, I_FetchStall, I_DepStall,
        output O_WriteBackEnable, O_WriteBackRegIdx, O_WriteBackData
    );
endinterface

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - pipeline writeback stage: RF write, NZP code, HALT latch
// Optional retire/bubble counters are built only when WB_PERF_COUNTERS_EN is defined.
module writeback_stage #(
    parameter int                      PC_WIDTH     = 16,
    parameter int                      REG_WIDTH    = 32,
    parameter int                      OPCODE_WIDTH = 8,
    parameter int                      CNT_WIDTH    = 32,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE  = 8'hFF,
    parameter logic [3:0]              LINK_REG     = 4'd7
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    writeback_stage_if.slave     wb,
    output logic [2:0]           O_CCode,
    output logic                 O_Halted,
    output logic [CNT_WIDTH-1:0] O_RetireCount,
    output logic [CNT_WIDTH-1:0] O_BubbleCount
);
    // Opcode encodings shared with global_def.h
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD_D  = 8'h10;
    localparam logic [OPCODE_WIDTH-1:0] OP_ADDI_D = 8'h11;
    localparam logic [OPCODE_WIDTH-1:0] OP_AND_D  = 8'h12;
    localparam logic [OPCODE_WIDTH-1:0] OP_ANDI_D = 8'h13;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOV    = 8'h14;
    localparam logic [OPCODE_WIDTH-1:0] OP_MOVI_D = 8'h15;
    localparam logic [OPCODE_WIDTH-1:0] OP_LDW    = 8'h20;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSR    = 8'h32;
    localparam logic [OPCODE_WIDTH-1:0] OP_JSRR   = 8'h33;

    typedef enum logic {S_RUN, S_HALTED} state_t;

    state_t               state_q, state_d;
    logic                 retire;
    logic                 is_alu, is_ldw, is_link;
    logic [REG_WIDTH-1:0] pc_ext;
    logic                 wbe_q, wbe_d;
    logic [3:0]           idx_q, idx_d;
    logic [REG_WIDTH-1:0] data_q, data_d;
    logic [2:0]           cc_q, cc_d;

    assign retire = (state_q == S_RUN) && wb.I_LOCK && !wb.I_FetchStall && !wb.I_DepStall;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) state_q <= S_RUN;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (retire && (wb.I_Opcode == HALT_OPCODE)) state_d = S_HALTED;
    end

    always_comb begin
        O_Halted = (state_q == S_HALTED);
    end

    generate
        if (PC_WIDTH >= REG_WIDTH) begin : g_pc_trunc
            assign pc_ext = wb.I_PC[REG_WIDTH-1:0];
        end else begin : g_pc_zext
            assign pc_ext = {{(REG_WIDTH-PC_WIDTH){1'b0}}, wb.I_PC};
        end
    endgenerate

    always_comb begin
        is_alu  = 1'b0;
        is_ldw  = 1'b0;
        is_link = 1'b0;
        case (wb.I_Opcode)
            OP_ADD_D, OP_ADDI_D, OP_AND_D,
            OP_ANDI_D, OP_MOV, OP_MOVI_D: is_alu  = 1'b1;
            OP_LDW:                       is_ldw  = 1'b1;
            OP_JSR, OP_JSRR:              is_link = 1'b1;
            default: ;
        endcase
    end

    // idx/data hold across non-writing cycles; CC tracks only R0-R7 writes
    always_comb begin
        wbe_d  = retire && (is_alu || is_ldw || is_link);
        idx_d  = idx_q;
        data_d = data_q;
        cc_d   = cc_q;
        if (wbe_d) begin
            idx_d  = is_link ? LINK_REG : wb.I_DestRegIdx;
            data_d = is_ldw ? wb.I_MemOut : (is_link ? pc_ext : wb.I_ALUOut);
            if (!idx_d[3]) begin
                if (data_d[REG_WIDTH-1])  cc_d = 3'b100;
                else if (data_d == '0)    cc_d = 3'b010;
                else                      cc_d = 3'b001;
            end
        end
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            wbe_q  <= 1'b0;
            idx_q  <= '0;
            data_q <= '0;
            cc_q   <= '0;
        end else begin
            wbe_q  <= wbe_d;
            idx_q  <= idx_d;
            data_q <= data_d;
            cc_q   <= cc_d;
        end
    end

    assign wb.O_WriteBackEnable = wbe_q;
    assign wb.O_WriteBackRegIdx = idx_q;
    assign wb.O_WriteBackData   = data_q;
    assign O_CCode              = cc_q;

`ifdef WB_PERF_COUNTERS_EN
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    logic                 bubble;
    logic [CNT_WIDTH-1:0] ret_q, ret_d, bub_q, bub_d;

    assign bubble = (state_q == S_RUN) && wb.I_LOCK && (wb.I_FetchStall || wb.I_DepStall);

    always_comb begin
        ret_d = ret_q;
        bub_d = bub_q;
        if (retire && (ret_q != '1)) ret_d = ret_q + CNT_ONE;
        if (bubble && (bub_q != '1)) bub_d = bub_q + CNT_ONE;
    end

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            ret_q <= '0;
            bub_q <= '0;
        end else begin
            ret_q <= ret_d;
            bub_q <= bub_d;
        end
    end

    assign O_RetireCount = ret_q;
    assign O_BubbleCount = bub_q;
`else
    assign O_RetireCount = '0;
    assign O_BubbleCount = '0;
`endif
endmodule
